vfpu_lod_arbiter: RTL and testbench
===================================

# vfpu_lod_arbiter

Round-robin scheduler that shares one `vfpu_lod` leading-one detector among `N_LANES` vector-FPU lanes needing normalization-shift amounts. Each lane has an independent valid/ready request port. The arbiter grants at most one lane per cycle, drives the granted operand into the internal `vfpu_lod` instance, and registers the result. The result is returned on a single tagged response channel with valid/ready backpressure. It sits between the lane mantissa datapaths and the normalization shifters in the VFPU.

## Interface
Parameters:
- `WIDTH`, 48, operand width in bits; passed to the internal `vfpu_lod`.
- `N_LANES`, 4, number of requesting lanes; must be ≥ 2.
- `LANE_W`, `$clog2(N_LANES)`, lane tag width (derived; do not override).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  `N_LANES`  per-lane request valid.
- `req_ready_o`  out  `N_LANES`  per-lane request accept; one-hot or zero.
- `req_data_i`  in  `N_LANES*WIDTH`  packed operands; lane `i` occupies `[i*WIDTH +: WIDTH]`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_lane_o`  out  `LANE_W`  index of the lane this response belongs to.
- `rsp_first_one_o`  out  `$clog2(WIDTH)`  bit index of the most significant 1 in the operand.
- `rsp_no_ones_o`  out  1  operand was all zeros.

## Operation
- Output register:
  - Holds `{lane, first_one, no_ones}` and the valid bit.
  - `free = !rsp_valid_o || rsp_ready_i`.
- Arbitration:
  - Round-robin priority pointer `ptr` (`LANE_W` bits).
  - Search lanes `ptr, ptr+1, …, N_LANES-1, 0, …, ptr-1` for the first asserted `req_valid_i`. That lane is `g`.
  - If a lane `g` is found and `free` is high, assert `req_ready_o[g]` only. Otherwise all `req_ready_o` are 0.
- Transfer:
  - A request is accepted when `req_valid_i[g] && req_ready_o[g]`.
  - The operand of `g` is routed to the `vfpu_lod` instance combinationally.
  - On that edge, the output register loads `lane=g`, the LOD result, and `rsp_valid_o=1`.
  - `ptr` is set to `(g+1) mod N_LANES`; the wrap from `N_LANES-1` goes to 0.
- No acceptance, `free` high:
  - `rsp_valid_o` clears if the previous response handshook (`rsp_valid_o && rsp_ready_i`).
  - `ptr` is unchanged.
- Stall (`rsp_valid_o && !rsp_ready_i`): every output register holds, all `req_ready_o` are 0, and `ptr` holds.
- Simultaneous response handshake and new acceptance in the same cycle: the new result overwrites the register and `rsp_valid_o` stays 1.
- LOD semantics:
  - `first_one` = index of the highest set bit (LSB = index 0).
  - For an all-zero operand: `no_ones=1`, `first_one=0`.
- `req_ready_o` may depend combinationally on `req_valid_i` and `rsp_ready_i`.
- `req_valid_i` must not depend on `req_ready_o`.
- Requesters hold valid and data stable until accepted.
- Reset:
  - `rst_i` high at an edge forces `rsp_valid_o=0`, `rsp_lane_o=0`, `rsp_first_one_o=0`, `rsp_no_ones_o=0`, `ptr=0`.
  - A pending response is discarded.
  - During reset, `req_ready_o` is all 0.

## Timing
- Latency: request accepted at edge `t`; response visible after edge `t`, i.e. in cycle `t+1`.
- Throughput: one response per cycle while `rsp_ready_i=1` and requests are pending.
- Combinational path: `req_valid_i` → priority search → mux → `vfpu_lod` → output register, all in one cycle.
- `rsp_*` outputs come directly from flops.
- Reset values: `rsp_valid_o=0`, `rsp_lane_o=0`, `rsp_first_one_o=0`, `rsp_no_ones_o=0`, `req_ready_o=0`.
- Fairness: a lane holding `req_valid_i` is granted within `N_LANES` accepting cycles.

## Test plan
- **Reset:** hold `rst_i` 2 cycles with all lanes valid → all outputs 0 and no `req_ready_o` during reset. After release, the first grant goes to lane 0.
- **Single request:** lane 2 only, data `48'h0F00F00FF0F0`, `rsp_ready_i=1` → `req_ready_o=4'b0100` for one cycle; next cycle `rsp_valid_o=1`, `rsp_lane_o=2`, `rsp_first_one_o=43`, `rsp_no_ones_o=0`.
- **Data corners on lane 0:**
  - `48'h8000F00FF0F0` → `first_one=47`.
  - `48'h000000000001` → `first_one=0`, `no_ones=0`.
  - `48'h0` → `first_one=0`, `no_ones=1`.
- **Round-robin:** all 4 lanes continuously valid, `rsp_ready_i=1` → response lane sequence 0,1,2,3,0,1,… with one response per cycle.
- **Backpressure:**
  - Lane 1 response pending, `rsp_ready_i=0` for 3 cycles → `rsp_*` stable, `req_ready_o=0`, `ptr` unchanged.
  - Raise `rsp_ready_i` → lane 2 accepted in that same cycle; its response follows with no bubble.
- **Reset mid-operation:** assert `rst_i` while `rsp_valid_o=1` and `ptr=3` → next cycle `rsp_valid_o=0`; after release, lane 0 wins over lane 3 when both are valid.

Source files
------------

// File: rtl/vfpu_lod_arbiter.sv
// Round-robin arbiter sharing one leading-one detector among N_LANES vector-FPU lanes.
// Latency: 1 cycle from request acceptance to registered, lane-tagged response.
// Backpressure: a stalled response (valid && !ready) holds all outputs and withholds every req_ready_o.

// Combinational leading-one detector: index of the highest set bit, plus an all-zero flag.
module vfpu_lod #(
  parameter int WIDTH = 48,
  parameter int FO_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [FO_W-1:0]  first_one,
  output logic             no_ones
);

  // Scan upward so the last hit is the most significant 1; all-zero leaves index 0.
  always_comb begin
    first_one = '0;
    no_ones   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        first_one = FO_W'(i);
        no_ones   = 1'b0;
      end
    end
  end

endmodule

module vfpu_lod_arbiter #(
  parameter int WIDTH   = 48,
  parameter int N_LANES = 4,
  parameter int LANE_W  = $clog2(N_LANES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_LANES-1:0]         req_valid_i,
  output logic [N_LANES-1:0]         req_ready_o,
  input  logic [N_LANES*WIDTH-1:0]   req_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [LANE_W-1:0]          rsp_lane_o,
  output logic [$clog2(WIDTH)-1:0]   rsp_first_one_o,
  output logic                       rsp_no_ones_o
);

  localparam int FO_W = $clog2(WIDTH);

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [FO_W-1:0]   first_one;
    logic              no_ones;
  } rsp_t;

  rsp_t              rsp_q;
  logic              rsp_valid_q;
  logic [LANE_W-1:0] ptr;

  logic              free;
  logic              found;
  logic              accept;
  logic [LANE_W-1:0] grant;
  logic [LANE_W-1:0] next_ptr;
  logic [WIDTH-1:0]  grant_dat;
  logic [FO_W-1:0]   lod_first_one;
  logic              lod_no_ones;

  // The output slot can take a new result if empty or being drained this cycle.
  assign free = !rsp_valid_q || rsp_ready_i;

  // Priority search starting at ptr and wrapping; first valid lane wins.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = (int'(ptr) + k) % N_LANES;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        grant = LANE_W'(idx);
      end
    end
  end

  assign accept      = found && free && !rst_i;
  assign req_ready_o = accept ? ({{(N_LANES-1){1'b0}}, 1'b1} << grant) : '0;
  assign grant_dat   = req_data_i[grant*WIDTH +: WIDTH];
  assign next_ptr    = (grant == LANE_W'(N_LANES-1)) ? '0 : grant + LANE_W'(1);

  vfpu_lod #(
    .WIDTH (WIDTH),
    .FO_W  (FO_W)
  ) u_lod (
    .data      (grant_dat),
    .first_one (lod_first_one),
    .no_ones   (lod_no_ones)
  );

  // Output register and round-robin pointer; a stall leaves everything untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr         <= '0;
    end else if (accept) begin
      rsp_valid_q       <= 1'b1;
      rsp_q.lane        <= grant;
      rsp_q.first_one   <= lod_first_one;
      rsp_q.no_ones     <= lod_no_ones;
      ptr               <= next_ptr;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_lane_o      = rsp_q.lane;
  assign rsp_first_one_o = rsp_q.first_one;
  assign rsp_no_ones_o   = rsp_q.no_ones;

endmodule

// File: tb/tb_vfpu_lod_arbiter.sv
// Randomized and directed bench for vfpu_lod_arbiter against a behavioural model.
// Latency: model predicts the response one cycle after each acceptance.
// Backpressure: random rsp_ready_i stalls; requesters hold valid/data until accepted.
module tb_vfpu_lod_arbiter;

  localparam int W  = 48;
  localparam int N  = 4;
  localparam int LW = 2;
  localparam int FW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [LW-1:0]   rsp_lane;
  logic [FW-1:0]   rsp_fo;
  logic            rsp_nz;

  always #5 clk = ~clk;

  vfpu_lod_arbiter #(.WIDTH(W), .N_LANES(N)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      (req_data),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_lane_o      (rsp_lane),
    .rsp_first_one_o (rsp_fo),
    .rsp_no_ones_o   (rsp_nz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester state held by the bench
  bit          lane_vld[N];
  logic [W-1:0] lane_dat[N];

  // Behavioural model of the response slot and fairness pointer
  int  m_ptr;
  bit  m_vld;
  int  m_lane;
  int  m_fo;
  bit  m_nz;
  bit  m_zero;

  // Outputs sampled during the last step
  logic          s_valid;
  logic [LW-1:0] s_lane;
  logic [FW-1:0] s_fo;
  logic          s_nz;
  logic [N-1:0]  s_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Position of the most significant 1, by repeated halving.
  function automatic int ref_fo(input logic [W-1:0] x);
    logic [W-1:0] v;
    int f;
    v = x;
    f = 0;
    while (v > 1) begin
      v = v >> 1;
      f++;
    end
    return f;
  endfunction

  // One clock: drive, check against the model, then advance the model across the edge.
  task automatic step(input bit rst_v, input bit rdy_v);
    int  g;
    bit  free;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst       = rst_v;
    rsp_ready = rdy_v;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = lane_vld[i];
      req_data[i*W +: W]    = lane_dat[i];
    end
    #1;
    g    = -1;
    free = !m_vld || rdy_v;
    if (!rst_v && free)
      for (int k = 0; k < N; k++)
        if (g < 0 && lane_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    s_valid = rsp_valid;
    s_lane  = rsp_lane;
    s_fo    = rsp_fo;
    s_nz    = rsp_nz;
    s_rdy   = req_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_vld));
    if (m_vld || m_zero) begin
      chk("rsp_lane", 64'(rsp_lane), 64'(m_lane));
      chk("rsp_first_one", 64'(rsp_fo), 64'(m_fo));
      chk("rsp_no_ones", 64'(rsp_nz), 64'(m_nz));
    end
    @(posedge clk);
    if (rst_v) begin
      m_vld = 0; m_lane = 0; m_fo = 0; m_nz = 0; m_ptr = 0; m_zero = 1;
    end else if (g >= 0) begin
      m_vld  = 1;
      m_lane = g;
      m_nz   = (lane_dat[g] == '0);
      m_fo   = m_nz ? 0 : ref_fo(lane_dat[g]);
      m_ptr  = (g + 1) % N;
      m_zero = 0;
      lane_vld[g] = 0;
    end else if (rdy_v) begin
      m_vld = 0;
    end
  endtask

  function automatic logic [W-1:0] rand_dat();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom % 4)
      0: return '0;
      1: return W'(64'd1 << ($urandom % W));
      2: return W'(t) >> ($urandom % W);
      default: return W'(t);
    endcase
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < N; i++) begin
      lane_vld[i] = 0;
      lane_dat[i] = '0;
    end
  endtask

  task automatic fill_lanes();
    for (int i = 0; i < N; i++)
      if (!lane_vld[i]) begin
        lane_vld[i] = 1;
        lane_dat[i] = rand_dat();
      end
  endtask

  task automatic corner(input logic [W-1:0] d, input int fo, input bit nz);
    lane_vld[0] = 1;
    lane_dat[0] = d;
    step(0, 1);
    step(0, 1);
    chk("corner_first_one", 64'(s_fo), 64'(fo));
    chk("corner_no_ones", 64'(s_nz), 64'(nz));
  endtask

  initial begin
    rst = 1; rsp_ready = 0; req_valid = '0; req_data = '0;
    m_ptr = 0; m_vld = 0; m_lane = 0; m_fo = 0; m_nz = 0; m_zero = 0;
    clear_lanes();

    // Reset held two cycles with every lane requesting
    fill_lanes();
    step(1, 1);
    step(1, 1);
    chk("reset_ready", 64'(s_rdy), 64'd0);
    step(0, 1);
    chk("reset_valid", 64'(s_valid), 64'd0);
    chk("reset_lane", 64'(s_lane), 64'd0);
    chk("first_grant", 64'(s_rdy), 64'd1);

    // Round-robin with all lanes continuously valid
    for (int t = 0; t < 9; t++) begin
      fill_lanes();
      step(0, 1);
      chk("rr_lane", 64'(s_lane), 64'(t % N));
      chk("rr_valid", 64'(s_valid), 64'd1);
    end

    // Single request on lane 2
    clear_lanes();
    step(1, 1);
    lane_vld[2] = 1;
    lane_dat[2] = 48'h0F00F00FF0F0;
    step(0, 1);
    chk("single_ready", 64'(s_rdy), 64'b0100);
    step(0, 1);
    chk("single_valid", 64'(s_valid), 64'd1);
    chk("single_lane", 64'(s_lane), 64'd2);
    chk("single_fo", 64'(s_fo), 64'd43);
    chk("single_nz", 64'(s_nz), 64'd0);

    // Operand corners on lane 0
    step(1, 1);
    corner(48'h8000F00FF0F0, 47, 0);
    corner(48'h000000000001, 0, 0);
    corner(48'h0, 0, 1);

    // Backpressure: lane 1 pending, ptr at 2
    step(1, 1);
    lane_vld[1] = 1; lane_dat[1] = 48'h000000F00000;
    step(0, 1);
    lane_vld[0] = 1; lane_dat[0] = rand_dat();
    lane_vld[2] = 1; lane_dat[2] = 48'h000400000000;
    lane_vld[3] = 1; lane_dat[3] = rand_dat();
    for (int t = 0; t < 3; t++) begin
      step(0, 0);
      chk("stall_lane", 64'(s_lane), 64'd1);
      chk("stall_ready", 64'(s_rdy), 64'd0);
    end
    step(0, 1);
    chk("release_ready", 64'(s_rdy), 64'b0100);
    step(0, 1);
    chk("release_valid", 64'(s_valid), 64'd1);
    chk("release_lane", 64'(s_lane), 64'd2);
    chk("release_fo", 64'(s_fo), 64'd34);

    // Reset while a response is pending and ptr sits at 3
    clear_lanes();
    step(1, 1);
    lane_vld[2] = 1; lane_dat[2] = rand_dat();
    step(0, 1);
    lane_vld[0] = 1; lane_dat[0] = rand_dat();
    lane_vld[3] = 1; lane_dat[3] = rand_dat();
    step(1, 0);
    chk("midrst_pending", 64'(s_valid), 64'd1);
    step(0, 1);
    chk("midrst_valid", 64'(s_valid), 64'd0);
    chk("midrst_grant", 64'(s_rdy), 64'b0001);
    step(0, 1);
    chk("midrst_lane", 64'(s_lane), 64'd0);

    // Randomized traffic with random backpressure and occasional reset
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (!lane_vld[i] && ($urandom % 2 == 0)) begin
          lane_vld[i] = 1;
          lane_dat[i] = rand_dat();
        end
      step(($urandom % 200) == 0, ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
